// File: rtl/rob_multiport_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_types
// Shared pipeline types for the reorder buffer and its neighbours.
//   ROB_DEPTH_DEFAULT : default reorder-buffer entry count
//   PREG_W_DEFAULT    : default physical register index width
//   rob_slot_t        : one reorder-buffer entry as seen by dispatch
// -----------------------------------------------------------------------------
package pipeline_types;

    localparam int ROB_DEPTH_DEFAULT = 32;
    localparam int PREG_W_DEFAULT    = 6;

    typedef struct packed {
        logic [4:0]                rd_arch;
        logic [PREG_W_DEFAULT-1:0] rd_new_preg;
        logic [PREG_W_DEFAULT-1:0] rd_old_preg;
        logic                      has_dest;
        logic                      is_branch;
        logic                      valid;
        logic                      done;
        logic                      mispredicted;
    } rob_slot_t;

endpackage

// File: rtl/rob_multiport_commit_sel.sv
// -----------------------------------------------------------------------------
// rob_commit_sel
// Picks the retire window starting at head: consecutive valid+done entries,
// at most COMMIT_W of them, ending early after the first mispredicted entry
// (which is itself retired as the last lane).
// Ports:
//   head_i        in   head pointer
//   valid_i       in   per-entry valid bits
//   done_i        in   per-entry done bits
//   mispred_i     in   per-entry mispredicted bits
//   commit_mask_o out  lanes retiring this cycle, packed from lane 0
//   commit_cnt_o  out  number of retiring lanes
//   flush_o       out  a mispredicted entry is in the window
//   flush_tag_o   out  tag of that mispredicted entry
// -----------------------------------------------------------------------------
module rob_commit_sel #(
    parameter int DEPTH    = 32,
    parameter int TAG_W    = $clog2(DEPTH),
    parameter int COMMIT_W = 2
) (
    input  logic [TAG_W-1:0]    head_i,
    input  logic [DEPTH-1:0]    valid_i,
    input  logic [DEPTH-1:0]    done_i,
    input  logic [DEPTH-1:0]    mispred_i,
    output logic [COMMIT_W-1:0] commit_mask_o,
    output logic [TAG_W:0]      commit_cnt_o,
    output logic                flush_o,
    output logic [TAG_W-1:0]    flush_tag_o
);

    always_comb begin
        logic [TAG_W-1:0] idx;
        logic             stop;
        idx           = '0;
        stop          = 1'b0;
        commit_mask_o = '0;
        commit_cnt_o  = '0;
        flush_o       = 1'b0;
        flush_tag_o   = '0;
        for (int i = 0; i < COMMIT_W; i++) begin
            idx = head_i + TAG_W'(i);
            if (!stop) begin
                if (valid_i[idx] && done_i[idx]) begin
                    commit_mask_o[i] = 1'b1;
                    commit_cnt_o     = commit_cnt_o + (TAG_W+1)'(1);
                    // A mispredicted branch closes the window; nothing younger retires.
                    if (mispred_i[idx]) begin
                        flush_o     = 1'b1;
                        flush_tag_o = idx;
                        stop        = 1'b1;
                    end
                end else begin
                    stop = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rob_multiport.sv
// -----------------------------------------------------------------------------
// rob_multiport
// Multi-lane reorder buffer: DISP_W dispatch lanes, CDB_N completion ports,
// COMMIT_W registered retire lanes, flush on retirement of a mispredicted
// branch. Full/empty are told apart by the occupancy counter alone.
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   disp_valid_i/entry_i per-lane dispatch request and payload (packed lanes)
//   disp_ready_o         all lanes may dispatch this cycle
//   alloc_tag_o          tag each lane would be given (tail + lane)
//   cdb_valid_i/tag_i    completion broadcasts
//   cdb_mispredict_i     completing branch was mispredicted
//   commit_valid_o       registered per-lane retire pulse
//   commit_old_preg_o    physical register to free per retiring lane
//   commit_has_dest_o    old preg valid per retiring lane
//   flush_o/flush_tag_o  registered flush pulse and offending branch tag
//   count_o, empty_o     occupancy
// -----------------------------------------------------------------------------
module rob_multiport
    import pipeline_types::*;
#(
    parameter int DEPTH    = ROB_DEPTH_DEFAULT,
    parameter int TAG_W    = $clog2(DEPTH),
    parameter int DISP_W   = 2,
    parameter int COMMIT_W = 2,
    parameter int CDB_N    = 2,
    parameter int PREG_W   = PREG_W_DEFAULT
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DISP_W-1:0]                disp_valid_i,
    input  rob_slot_t [DISP_W-1:0]           disp_entry_i,
    output logic                             disp_ready_o,
    output logic [DISP_W-1:0][TAG_W-1:0]     alloc_tag_o,
    input  logic [CDB_N-1:0]                 cdb_valid_i,
    input  logic [CDB_N-1:0][TAG_W-1:0]      cdb_tag_i,
    input  logic [CDB_N-1:0]                 cdb_mispredict_i,
    output logic [COMMIT_W-1:0]              commit_valid_o,
    output logic [COMMIT_W-1:0][PREG_W-1:0]  commit_old_preg_o,
    output logic [COMMIT_W-1:0]              commit_has_dest_o,
    output logic                             flush_o,
    output logic [TAG_W-1:0]                 flush_tag_o,
    output logic [TAG_W:0]                   count_o,
    output logic                             empty_o
);

    localparam int CNT_W = TAG_W + 1;

    logic [TAG_W-1:0]                head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]                count_q, count_d;
    logic [DEPTH-1:0]                valid_q, valid_d;
    logic [DEPTH-1:0]                done_q, done_d;
    logic [DEPTH-1:0]                mispred_q, mispred_d;
    logic [DEPTH-1:0]                has_dest_q, has_dest_d;
    logic [PREG_W-1:0]               old_preg_q [DEPTH];
    logic [PREG_W-1:0]               old_preg_d [DEPTH];
    logic [COMMIT_W-1:0]             commit_valid_q, commit_valid_d;
    logic [COMMIT_W-1:0][PREG_W-1:0] commit_old_preg_q, commit_old_preg_d;
    logic [COMMIT_W-1:0]             commit_has_dest_q, commit_has_dest_d;
    logic                            flush_q, flush_d;
    logic [TAG_W-1:0]                flush_tag_q, flush_tag_d;

    logic [COMMIT_W-1:0]             sel_mask;
    logic [CNT_W-1:0]                sel_cnt;
    logic                            sel_flush;
    logic [TAG_W-1:0]                sel_flush_tag;
    logic [CNT_W-1:0]                free_slots;
    logic                            unused_disp_fields;

    rob_commit_sel #(
        .DEPTH    (DEPTH),
        .TAG_W    (TAG_W),
        .COMMIT_W (COMMIT_W)
    ) u_commit_sel (
        .head_i        (head_q),
        .valid_i       (valid_q),
        .done_i        (done_q),
        .mispred_i     (mispred_q),
        .commit_mask_o (sel_mask),
        .commit_cnt_o  (sel_cnt),
        .flush_o       (sel_flush),
        .flush_tag_o   (sel_flush_tag)
    );

    // Dispatch is held off while a flush is being retired so nothing lands
    // in slots that are about to be discarded.
    assign free_slots   = CNT_W'(DEPTH) - count_q;
    assign disp_ready_o = (free_slots >= CNT_W'(DISP_W)) && !sel_flush;

    always_comb begin
        alloc_tag_o = '0;
        for (int i = 0; i < DISP_W; i++) begin
            alloc_tag_o[i] = tail_q + TAG_W'(i);
        end
    end

    // Control bits of the dispatched payload are regenerated here, and the
    // remaining fields belong to other pipeline stages.
    always_comb begin
        unused_disp_fields = 1'b0;
        for (int i = 0; i < DISP_W; i++) begin
            unused_disp_fields = unused_disp_fields ^ (^{disp_entry_i[i].rd_arch,
                disp_entry_i[i].rd_new_preg, disp_entry_i[i].is_branch,
                disp_entry_i[i].valid, disp_entry_i[i].done,
                disp_entry_i[i].mispredicted});
        end
    end

    always_comb begin
        logic [TAG_W-1:0] idx;
        logic [CNT_W-1:0] disp_cnt;
        idx               = '0;
        disp_cnt          = '0;
        head_d            = head_q;
        tail_d            = tail_q;
        count_d           = count_q;
        valid_d           = valid_q;
        done_d            = done_q;
        mispred_d         = mispred_q;
        has_dest_d        = has_dest_q;
        old_preg_d        = old_preg_q;
        commit_valid_d    = '0;
        commit_old_preg_d = commit_old_preg_q;
        commit_has_dest_d = commit_has_dest_q;
        flush_d           = 1'b0;
        flush_tag_d       = flush_tag_q;

        for (int i = 0; i < COMMIT_W; i++) begin
            if (sel_mask[i]) begin
                idx                  = head_q + TAG_W'(i);
                valid_d[idx]         = 1'b0;
                commit_valid_d[i]    = 1'b1;
                commit_old_preg_d[i] = old_preg_q[idx];
                commit_has_dest_d[i] = has_dest_q[idx];
            end
        end

        if (sel_flush) begin
            // Everything younger than the branch is wrong-path; restart just after it.
            valid_d     = '0;
            head_d      = sel_flush_tag + TAG_W'(1);
            tail_d      = sel_flush_tag + TAG_W'(1);
            count_d     = '0;
            flush_d     = 1'b1;
            flush_tag_d = sel_flush_tag;
        end else begin
            for (int p = 0; p < CDB_N; p++) begin
                if (cdb_valid_i[p] && valid_q[cdb_tag_i[p]]) begin
                    done_d[cdb_tag_i[p]]    = 1'b1;
                    mispred_d[cdb_tag_i[p]] = mispred_d[cdb_tag_i[p]] | cdb_mispredict_i[p];
                end
            end
            if (disp_ready_o) begin
                for (int i = 0; i < DISP_W; i++) begin
                    if (disp_valid_i[i]) begin
                        idx             = tail_q + TAG_W'(i);
                        valid_d[idx]    = 1'b1;
                        done_d[idx]     = 1'b0;
                        mispred_d[idx]  = 1'b0;
                        old_preg_d[idx] = PREG_W'(disp_entry_i[i].rd_old_preg);
                        has_dest_d[idx] = disp_entry_i[i].has_dest;
                        disp_cnt        = disp_cnt + CNT_W'(1);
                    end
                end
            end
            head_d  = head_q + sel_cnt[TAG_W-1:0];
            tail_d  = tail_q + disp_cnt[TAG_W-1:0];
            count_d = count_q + disp_cnt - sel_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q            <= '0;
            tail_q            <= '0;
            count_q           <= '0;
            valid_q           <= '0;
            commit_valid_q    <= '0;
            commit_old_preg_q <= '0;
            commit_has_dest_q <= '0;
            flush_q           <= 1'b0;
            flush_tag_q       <= '0;
        end else begin
            head_q            <= head_d;
            tail_q            <= tail_d;
            count_q           <= count_d;
            valid_q           <= valid_d;
            commit_valid_q    <= commit_valid_d;
            commit_old_preg_q <= commit_old_preg_d;
            commit_has_dest_q <= commit_has_dest_d;
            flush_q           <= flush_d;
            flush_tag_q       <= flush_tag_d;
        end
    end

    // Entry payload and status are qualified by valid_q, so they need no reset.
    always_ff @(posedge clk) begin
        done_q     <= done_d;
        mispred_q  <= mispred_d;
        has_dest_q <= has_dest_d;
        old_preg_q <= old_preg_d;
    end

    assign commit_valid_o    = commit_valid_q;
    assign commit_old_preg_o = commit_old_preg_q;
    assign commit_has_dest_o = commit_has_dest_q;
    assign flush_o           = flush_q;
    assign flush_tag_o       = flush_tag_q;
    assign count_o           = count_q;
    assign empty_o           = (count_q == '0);

    // Dispatch lanes must be packed from lane 0.
    for (genvar g = 1; g < DISP_W; g++) begin : g_pack_chk
        a_disp_packed: assert property (@(posedge clk) disable iff (rst)
            disp_valid_i[g] |-> disp_valid_i[g-1]);
    end

endmodule

// File: tb/tb_rob_multiport.sv
module tb_rob_multiport;
    import pipeline_types::*;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      disp_valid;
    rob_slot_t [1:0] disp_entry;
    logic            disp_ready;
    logic [1:0][4:0] alloc_tag;
    logic [1:0]      cdb_valid;
    logic [1:0][4:0] cdb_tag;
    logic [1:0]      cdb_mp;
    logic [1:0]      commit_valid;
    logic [1:0][5:0] commit_old_preg;
    logic [1:0]      commit_has_dest;
    logic            flush;
    logic [4:0]      flush_tag;
    logic [5:0]      count;
    logic            empty;

    int n_cmp = 0;
    int n_bad = 0;

    rob_multiport #(
        .DEPTH(32), .TAG_W(5), .DISP_W(2), .COMMIT_W(2), .CDB_N(2), .PREG_W(6)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .disp_valid_i      (disp_valid),
        .disp_entry_i      (disp_entry),
        .disp_ready_o      (disp_ready),
        .alloc_tag_o       (alloc_tag),
        .cdb_valid_i       (cdb_valid),
        .cdb_tag_i         (cdb_tag),
        .cdb_mispredict_i  (cdb_mp),
        .commit_valid_o    (commit_valid),
        .commit_old_preg_o (commit_old_preg),
        .commit_has_dest_o (commit_has_dest),
        .flush_o           (flush),
        .flush_tag_o       (flush_tag),
        .count_o           (count),
        .empty_o           (empty)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Payload for a given tag: old preg = tag+1, has_dest set on even tags.
    function automatic rob_slot_t make_slot(input int tag);
        rob_slot_t s;
        s = '0;
        s.rd_arch     = 5'(tag);
        s.rd_new_preg = 6'(tag + 33);
        s.rd_old_preg = 6'(tag + 1);
        s.has_dest    = (tag % 2 == 0);
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        disp_valid = '0;
        cdb_valid  = '0;
        cdb_mp     = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        disp_entry = '0;
        cdb_tag    = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic dispatch_pair(input int t0);
        disp_valid    = 2'b11;
        disp_entry[0] = make_slot(t0);
        disp_entry[1] = make_slot((t0 + 1) % 32);
        tick();
        idle();
    endtask

    task automatic cdb2(input logic [1:0] v, input int t0, input logic m0,
                        input int t1, input logic m1);
        cdb_valid  = v;
        cdb_tag[0] = 5'(t0);
        cdb_tag[1] = 5'(t1);
        cdb_mp     = {m1, m0};
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (count !== 6'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty: got %b want 1", empty); end
        n_cmp++; if (disp_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", disp_ready); end
        n_cmp++; if (commit_valid !== 2'b00) begin n_bad++; $display("FAIL reset_commit_valid: got %b want 00", commit_valid); end
        n_cmp++; if (flush !== 1'b0) begin n_bad++; $display("FAIL reset_flush: got %b want 0", flush); end
        n_cmp++; if (commit_old_preg !== 12'h000) begin n_bad++; $display("FAIL reset_old_preg: got %h want 000", commit_old_preg); end
        n_cmp++; if (flush_tag !== 5'd0) begin n_bad++; $display("FAIL reset_flush_tag: got %0d want 0", flush_tag); end
        n_cmp++; if (alloc_tag[0] !== 5'd0 || alloc_tag[1] !== 5'd1) begin n_bad++; $display("FAIL reset_alloc: got %0d,%0d want 0,1", alloc_tag[0], alloc_tag[1]); end
    endtask

    task automatic test_fill();
        for (int c = 0; c < 16; c++) begin
            disp_valid    = 2'b11;
            disp_entry[0] = make_slot(2 * c);
            disp_entry[1] = make_slot(2 * c + 1);
            #1;
            n_cmp++; if (alloc_tag[0] !== 5'(2 * c) || alloc_tag[1] !== 5'(2 * c + 1)) begin n_bad++; $display("FAIL fill_alloc: got %0d,%0d want %0d,%0d", alloc_tag[0], alloc_tag[1], 2 * c, 2 * c + 1); end
            n_cmp++; if (disp_ready !== 1'b1) begin n_bad++; $display("FAIL fill_ready: cycle %0d got %b want 1", c, disp_ready); end
            tick();
        end
        idle();
        n_cmp++; if (count !== 6'd32) begin n_bad++; $display("FAIL fill_count: got %0d want 32", count); end
        n_cmp++; if (disp_ready !== 1'b0) begin n_bad++; $display("FAIL fill_full_ready: got %b want 0", disp_ready); end
        n_cmp++; if (empty !== 1'b0) begin n_bad++; $display("FAIL fill_empty: got %b want 0", empty); end
        n_cmp++; if (commit_valid !== 2'b00) begin n_bad++; $display("FAIL fill_no_commit: got %b want 00", commit_valid); end
    endtask

    task automatic test_dual_commit();
        cdb2(2'b11, 0, 1'b0, 1, 1'b0);
        tick();
        idle();
        n_cmp++; if (commit_valid !== 2'b00) begin n_bad++; $display("FAIL dual_latency: got %b want 00", commit_valid); end
        n_cmp++; if (count !== 6'd32) begin n_bad++; $display("FAIL dual_count_before: got %0d want 32", count); end
        tick();
        n_cmp++; if (commit_valid !== 2'b11) begin n_bad++; $display("FAIL dual_commit_valid: got %b want 11", commit_valid); end
        n_cmp++; if (commit_old_preg[0] !== 6'd1 || commit_old_preg[1] !== 6'd2) begin n_bad++; $display("FAIL dual_old_preg: got %0d,%0d want 1,2", commit_old_preg[0], commit_old_preg[1]); end
        n_cmp++; if (commit_has_dest !== 2'b01) begin n_bad++; $display("FAIL dual_has_dest: got %b want 01", commit_has_dest); end
        n_cmp++; if (count !== 6'd30) begin n_bad++; $display("FAIL dual_count: got %0d want 30", count); end
        n_cmp++; if (disp_ready !== 1'b1) begin n_bad++; $display("FAIL dual_ready: got %b want 1", disp_ready); end
        tick();
        n_cmp++; if (commit_valid !== 2'b00) begin n_bad++; $display("FAIL dual_single_pulse: got %b want 00", commit_valid); end
    endtask

    task automatic test_out_of_order();
        cdb2(2'b01, 3, 1'b0, 0, 1'b0);
        tick();
        idle();
        tick();
        n_cmp++; if (commit_valid !== 2'b00) begin n_bad++; $display("FAIL ooo_hold: got %b want 00", commit_valid); end
        n_cmp++; if (count !== 6'd30) begin n_bad++; $display("FAIL ooo_hold_count: got %0d want 30", count); end
        cdb2(2'b01, 2, 1'b0, 0, 1'b0);
        tick();
        idle();
        n_cmp++; if (commit_valid !== 2'b00) begin n_bad++; $display("FAIL ooo_latency: got %b want 00", commit_valid); end
        tick();
        n_cmp++; if (commit_valid !== 2'b11) begin n_bad++; $display("FAIL ooo_commit_valid: got %b want 11", commit_valid); end
        n_cmp++; if (commit_old_preg[0] !== 6'd3 || commit_old_preg[1] !== 6'd4) begin n_bad++; $display("FAIL ooo_old_preg: got %0d,%0d want 3,4", commit_old_preg[0], commit_old_preg[1]); end
        n_cmp++; if (count !== 6'd28) begin n_bad++; $display("FAIL ooo_count: got %0d want 28", count); end
    endtask

    task automatic test_wrap_simultaneous();
        do_reset();
        for (int c = 0; c < 15; c++) dispatch_pair(2 * c);
        disp_valid    = 2'b01;
        disp_entry[0] = make_slot(30);
        tick();
        idle();
        n_cmp++; if (count !== 6'd31) begin n_bad++; $display("FAIL wrap_count31: got %0d want 31", count); end
        n_cmp++; if (disp_ready !== 1'b0) begin n_bad++; $display("FAIL wrap_one_free_ready: got %b want 0", disp_ready); end
        n_cmp++; if (alloc_tag[0] !== 5'd31) begin n_bad++; $display("FAIL wrap_tail31: got %0d want 31", alloc_tag[0]); end
        cdb2(2'b11, 0, 1'b0, 1, 1'b0);
        tick();
        idle();
        tick();
        n_cmp++; if (count !== 6'd29) begin n_bad++; $display("FAIL wrap_count29: got %0d want 29", count); end
        cdb2(2'b11, 2, 1'b0, 3, 1'b0);
        tick();
        idle();
        disp_valid    = 2'b11;
        disp_entry[0] = make_slot(31);
        disp_entry[1] = make_slot(0);
        #1;
        n_cmp++; if (disp_ready !== 1'b1) begin n_bad++; $display("FAIL wrap_ready: got %b want 1", disp_ready); end
        n_cmp++; if (alloc_tag[0] !== 5'd31 || alloc_tag[1] !== 5'd0) begin n_bad++; $display("FAIL wrap_alloc: got %0d,%0d want 31,0", alloc_tag[0], alloc_tag[1]); end
        tick();
        idle();
        n_cmp++; if (commit_valid !== 2'b11) begin n_bad++; $display("FAIL wrap_commit_valid: got %b want 11", commit_valid); end
        n_cmp++; if (commit_old_preg[0] !== 6'd3 || commit_old_preg[1] !== 6'd4) begin n_bad++; $display("FAIL wrap_old_preg: got %0d,%0d want 3,4", commit_old_preg[0], commit_old_preg[1]); end
        n_cmp++; if (count !== 6'd29) begin n_bad++; $display("FAIL wrap_count_simul: got %0d want 29", count); end
        n_cmp++; if (alloc_tag[0] !== 5'd1 || alloc_tag[1] !== 5'd2) begin n_bad++; $display("FAIL wrap_tail_after: got %0d,%0d want 1,2", alloc_tag[0], alloc_tag[1]); end
    endtask

    task automatic test_mispredict();
        do_reset();
        for (int c = 0; c < 5; c++) dispatch_pair(2 * c);
        cdb2(2'b11, 0, 1'b0, 1, 1'b0);
        tick();
        cdb2(2'b01, 2, 1'b0, 0, 1'b0);
        tick();
        idle();
        tick();
        n_cmp++; if (count !== 6'd7) begin n_bad++; $display("FAIL mp_setup_count: got %0d want 7", count); end
        // Younger entries 5 and 6 complete first; they must be discarded by the flush.
        cdb2(2'b11, 5, 1'b0, 6, 1'b0);
        tick();
        idle();
        tick();
        n_cmp++; if (commit_valid !== 2'b00) begin n_bad++; $display("FAIL mp_blocked: got %b want 00", commit_valid); end
        cdb2(2'b11, 4, 1'b1, 3, 1'b0);
        tick();
        idle();
        n_cmp++; if (disp_ready !== 1'b0) begin n_bad++; $display("FAIL mp_pending_ready: got %b want 0", disp_ready); end
        disp_valid    = 2'b11;
        disp_entry[0] = make_slot(20);
        disp_entry[1] = make_slot(21);
        cdb2(2'b01, 7, 1'b0, 0, 1'b0);
        tick();
        idle();
        n_cmp++; if (commit_valid !== 2'b11) begin n_bad++; $display("FAIL mp_commit_valid: got %b want 11", commit_valid); end
        n_cmp++; if (commit_old_preg[0] !== 6'd4 || commit_old_preg[1] !== 6'd5) begin n_bad++; $display("FAIL mp_old_preg: got %0d,%0d want 4,5", commit_old_preg[0], commit_old_preg[1]); end
        n_cmp++; if (flush !== 1'b1) begin n_bad++; $display("FAIL mp_flush: got %b want 1", flush); end
        n_cmp++; if (flush_tag !== 5'd4) begin n_bad++; $display("FAIL mp_flush_tag: got %0d want 4", flush_tag); end
        n_cmp++; if (count !== 6'd0 || empty !== 1'b1) begin n_bad++; $display("FAIL mp_count: got %0d/%b want 0/1", count, empty); end
        n_cmp++; if (alloc_tag[0] !== 5'd5) begin n_bad++; $display("FAIL mp_tail: got %0d want 5", alloc_tag[0]); end
        tick();
        n_cmp++; if (flush !== 1'b0) begin n_bad++; $display("FAIL mp_flush_pulse: got %b want 0", flush); end
        n_cmp++; if (commit_valid !== 2'b00) begin n_bad++; $display("FAIL mp_younger_killed: got %b want 00", commit_valid); end
        n_cmp++; if (count !== 6'd0) begin n_bad++; $display("FAIL mp_count_after: got %0d want 0", count); end
        n_cmp++; if (disp_ready !== 1'b1) begin n_bad++; $display("FAIL mp_ready_after: got %b want 1", disp_ready); end
    endtask

    task automatic test_mispredict_lane0();
        dispatch_pair(5);
        cdb2(2'b11, 5, 1'b1, 6, 1'b0);
        tick();
        idle();
        tick();
        n_cmp++; if (commit_valid !== 2'b01) begin n_bad++; $display("FAIL mp0_commit_valid: got %b want 01", commit_valid); end
        n_cmp++; if (commit_old_preg[0] !== 6'd6) begin n_bad++; $display("FAIL mp0_old_preg: got %0d want 6", commit_old_preg[0]); end
        n_cmp++; if (flush !== 1'b1 || flush_tag !== 5'd5) begin n_bad++; $display("FAIL mp0_flush: got %b/%0d want 1/5", flush, flush_tag); end
        n_cmp++; if (count !== 6'd0) begin n_bad++; $display("FAIL mp0_count: got %0d want 0", count); end
        n_cmp++; if (alloc_tag[0] !== 5'd6) begin n_bad++; $display("FAIL mp0_tail: got %0d want 6", alloc_tag[0]); end
        tick();
        n_cmp++; if (commit_valid !== 2'b00) begin n_bad++; $display("FAIL mp0_lane1_killed: got %b want 00", commit_valid); end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        for (int c = 0; c < 10; c++) dispatch_pair(2 * c);
        n_cmp++; if (count !== 6'd20) begin n_bad++; $display("FAIL rmid_setup: got %0d want 20", count); end
        cdb2(2'b11, 0, 1'b0, 1, 1'b0);
        tick();
        rst = 1'b1;
        cdb2(2'b11, 2, 1'b0, 3, 1'b0);
        tick();
        n_cmp++; if (count !== 6'd0 || empty !== 1'b1) begin n_bad++; $display("FAIL rmid_count: got %0d/%b want 0/1", count, empty); end
        n_cmp++; if (commit_valid !== 2'b00) begin n_bad++; $display("FAIL rmid_commit_dominated: got %b want 00", commit_valid); end
        rst = 1'b0;
        idle();
        tick();
        n_cmp++; if (commit_valid !== 2'b00) begin n_bad++; $display("FAIL rmid_no_commit_after: got %b want 00", commit_valid); end
        n_cmp++; if (count !== 6'd0 || alloc_tag[0] !== 5'd0) begin n_bad++; $display("FAIL rmid_state: got %0d/%0d want 0/0", count, alloc_tag[0]); end
    endtask

    initial begin
        rst        = 1'b1;
        disp_valid = '0;
        disp_entry = '0;
        cdb_valid  = '0;
        cdb_tag    = '0;
        cdb_mp     = '0;
        test_reset();
        test_fill();
        test_dual_commit();
        test_out_of_order();
        test_wrap_simultaneous();
        test_mispredict();
        test_mispredict_lane0();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
